// File: rtl/arbiter_2to1.sv
// Packet-aware 2:1 NoC flit arbiter: round-robin between two sources at packet
// boundaries, never interleaving packets, with a single registered output stage.
module arbiter_2to1 #(
   parameter int unsigned NOC_WIDTH = 600
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NOC_WIDTH-1:0] i_data1_in,
   input  logic                 i_valid1_in,
   output logic                 i_ready1_out,
   input  logic [NOC_WIDTH-1:0] i_data2_in,
   input  logic                 i_valid2_in,
   output logic                 i_ready2_out,
   output logic [NOC_WIDTH-1:0] o_data_out,
   output logic                 o_valid_out,
   input  logic                 o_ready_in
);

   localparam int unsigned HEAD_BIT = NOC_WIDTH - 2;
   localparam int unsigned TAIL_0   = NOC_WIDTH - 3;
   localparam int unsigned TAIL_1   = (3 * NOC_WIDTH) / 4 - 3;
   localparam int unsigned TAIL_2   = NOC_WIDTH / 2 - 3;
   localparam int unsigned TAIL_3   = NOC_WIDTH / 4 - 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOCK1 = 2'd1,
      S_LOCK2 = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_last2;
   logic                 w_last2_nxt;
   logic                 r_valid;
   logic [NOC_WIDTH-1:0] r_data;

   logic                 w_load_en;
   logic                 w_grant1;
   logic                 w_grant2;
   logic                 w_xfer1;
   logic                 w_xfer2;
   logic                 w_xfer;
   logic                 w_head;
   logic                 w_tail;
   logic [NOC_WIDTH-1:0] w_word;

   // State register; r_last2 high means source 2 was served last.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_last2 <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_last2 <= w_last2_nxt;
      end
   end

   // Grant: locked source owns the port; otherwise round-robin on ties.
   always_comb begin
      w_grant1 = 1'b0;
      w_grant2 = 1'b0;
      case (r_state)
         S_LOCK1: w_grant1 = 1'b1;
         S_LOCK2: w_grant2 = 1'b1;
         default: begin
            w_grant1 = i_valid1_in && (!i_valid2_in || r_last2);
            w_grant2 = i_valid2_in && (!i_valid1_in || !r_last2);
         end
      endcase
   end

   assign w_load_en    = !r_valid || o_ready_in;
   assign i_ready1_out = w_grant1 && w_load_en;
   assign i_ready2_out = w_grant2 && w_load_en;
   assign w_xfer1      = i_valid1_in && i_ready1_out;
   assign w_xfer2      = i_valid2_in && i_ready2_out;
   assign w_xfer       = w_xfer1 || w_xfer2;
   assign w_word       = w_xfer2 ? i_data2_in : i_data1_in;
   assign w_head       = w_word[HEAD_BIT];
   assign w_tail       = w_word[TAIL_0] | w_word[TAIL_1] | w_word[TAIL_2] | w_word[TAIL_3];

   // Next state: lock on a head in IDLE, release on any tail.
   always_comb begin
      w_state_nxt = r_state;
      w_last2_nxt = r_last2;
      if (w_xfer) begin
         if (w_tail) begin
            w_state_nxt = S_IDLE;
            w_last2_nxt = w_xfer2;
         end else if (w_head && (r_state == S_IDLE)) begin
            w_state_nxt = w_xfer2 ? S_LOCK2 : S_LOCK1;
         end
      end
   end

   // Output register: load on transfer, drain when the fabric accepts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (w_load_en) begin
         r_valid <= w_xfer;
         if (w_xfer) begin
            r_data <= w_word;
         end
      end
   end

   assign o_valid_out = r_valid;
   assign o_data_out  = r_data;

endmodule

// File: tb/tb_arbiter_2to1.sv
// Self-checking bench for arbiter_2to1: vector table, directed corner cases and
// randomized packet traffic against a behavioural model.
module tb_arbiter_2to1;

   localparam int unsigned W = 600;

   logic         clk;
   logic         reset;
   logic [W-1:0] i_data1_in;
   logic         i_valid1_in;
   logic         i_ready1_out;
   logic [W-1:0] i_data2_in;
   logic         i_valid2_in;
   logic         i_ready2_out;
   logic [W-1:0] o_data_out;
   logic         o_valid_out;
   logic         o_ready_in;

   int checks;
   int failures;

   // Behavioural model: owner of the port (0 = nobody), last served source, output stage.
   int           m_owner;
   int           m_last;
   bit           m_ov;
   logic [W-1:0] m_od;

   arbiter_2to1 #(.NOC_WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_data1_in   (i_data1_in),
      .i_valid1_in  (i_valid1_in),
      .i_ready1_out (i_ready1_out),
      .i_data2_in   (i_data2_in),
      .i_valid2_in  (i_valid2_in),
      .i_ready2_out (i_ready2_out),
      .o_data_out   (o_data_out),
      .o_valid_out  (o_valid_out),
      .o_ready_in   (o_ready_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit           v1;
      logic [W-1:0] d1;
      bit           v2;
      logic [W-1:0] d2;
      bit           ordy;
      bit           er1;
      bit           er2;
      bit           eov;
      logic [15:0]  etag;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b required=%0b", name, act, exp);
      end
   endtask

   // Flit builder: tag {src, seq} in bits 15:0, tail marker in one of the four sub-flits.
   function automatic logic [W-1:0] mk(input int s, input int q, input bit h, input bit t,
                                       input int p, input bit rnd);
      logic [W-1:0] w;
      w = '0;
      if (rnd) for (int i = 0; i < int'(W); i++) w[i] = 1'($urandom_range(0, 1));
      w[W-2]       = h;
      w[W-3]       = 1'b0;
      w[3*W/4-3]   = 1'b0;
      w[W/2-3]     = 1'b0;
      w[W/4-3]     = 1'b0;
      if (t) begin
         case (p)
            0:       w[W-3]     = 1'b1;
            1:       w[3*W/4-3] = 1'b1;
            2:       w[W/2-3]   = 1'b1;
            default: w[W/4-3]   = 1'b1;
         endcase
      end
      w[15:12] = 4'(s);
      w[11:0]  = 12'(q);
      return w;
   endfunction

   function automatic vec_t vr(input bit v1, input logic [W-1:0] d1, input bit v2,
                               input logic [W-1:0] d2, input bit ordy, input bit er1,
                               input bit er2, input bit eov, input logic [15:0] etag);
      vec_t v;
      v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2; v.ordy = ordy;
      v.er1 = er1; v.er2 = er2; v.eov = eov; v.etag = etag;
      return v;
   endfunction

   function automatic bit is_tail(input logic [W-1:0] w);
      return w[W-3] || w[3*W/4-3] || w[W/2-3] || w[W/4-3];
   endfunction

   task automatic model_reset();
      m_owner = 0;
      m_last  = 2;
      m_ov    = 1'b0;
      m_od    = '0;
   endtask

   // Compare DUT against the model for the current inputs, advance one clock.
   task automatic step(output int xk);
      int           g;
      bit           ld;
      bit           er1;
      bit           er2;
      logic [W-1:0] w;
      #2;
      ld = !m_ov || o_ready_in;
      if (m_owner != 0)                  g = m_owner;
      else if (i_valid1_in && i_valid2_in) g = (m_last == 1) ? 2 : 1;
      else if (i_valid1_in)              g = 1;
      else if (i_valid2_in)              g = 2;
      else                               g = 0;
      er1 = (g == 1) && ld;
      er2 = (g == 2) && ld;
      chkb("o_valid", o_valid_out, m_ov);
      chk("o_data", o_data_out, m_od);
      chkb("ready1", i_ready1_out, er1);
      chkb("ready2", i_ready2_out, er2);
      xk = 0;
      if (i_valid1_in && er1)      xk = 1;
      else if (i_valid2_in && er2) xk = 2;
      if (xk != 0) begin
         w = (xk == 1) ? i_data1_in : i_data2_in;
         if (is_tail(w)) begin
            m_owner = 0;
            m_last  = xk;
         end else if (w[W-2] && m_owner == 0) begin
            m_owner = xk;
         end
         m_ov = 1'b1;
         m_od = w;
      end else if (ld) begin
         m_ov = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v1, input logic [W-1:0] d1, input bit v2,
                        input logic [W-1:0] d2, input bit ordy);
      i_valid1_in = v1;
      i_data1_in  = d1;
      i_valid2_in = v2;
      i_data2_in  = d2;
      o_ready_in  = ordy;
   endtask

   int           xk;
   int           slen [1:2];
   int           sidx [1:2];
   int           sseq [1:2];
   logic [W-1:0] scur [1:2];
   bit           sval [1:2];

   initial begin
      checks   = 0;
      failures = 0;
      model_reset();
      reset = 1'b1;
      drive(1'b0, '0, 1'b0, '0, 1'b1);

      // Vectors: idle, contention with lock, round-robin on single-word packets.
      tbl[0]  = vr(0, '0,                0, '0,                1, 0, 0, 0, 16'h0000);
      tbl[1]  = vr(1, mk(1,0,1,0,0,0),   1, mk(2,0,1,0,0,0),   1, 1, 0, 0, 16'h0000);
      tbl[2]  = vr(1, mk(1,1,0,0,0,0),   1, mk(2,0,1,0,0,0),   1, 1, 0, 1, 16'h1000);
      tbl[3]  = vr(1, mk(1,2,0,1,0,0),   1, mk(2,0,1,0,0,0),   1, 1, 0, 1, 16'h1001);
      tbl[4]  = vr(0, '0,                1, mk(2,0,1,0,0,0),   1, 0, 1, 1, 16'h1002);
      tbl[5]  = vr(0, '0,                1, mk(2,1,0,0,0,0),   1, 0, 1, 1, 16'h2000);
      tbl[6]  = vr(0, '0,                1, mk(2,2,0,1,1,0),   1, 0, 1, 1, 16'h2001);
      tbl[7]  = vr(1, mk(1,3,1,1,3,0),   1, mk(2,3,1,1,3,0),   1, 1, 0, 1, 16'h2002);
      tbl[8]  = vr(1, mk(1,4,1,1,3,0),   1, mk(2,3,1,1,3,0),   1, 0, 1, 1, 16'h1003);
      tbl[9]  = vr(1, mk(1,4,1,1,3,0),   1, mk(2,4,1,1,3,0),   1, 1, 0, 1, 16'h2003);
      tbl[10] = vr(1, mk(1,5,1,1,3,0),   1, mk(2,4,1,1,3,0),   1, 0, 1, 1, 16'h1004);
      tbl[11] = vr(0, '0,                0, '0,                1, 0, 0, 1, 16'h2004);
      tbl[12] = vr(0, '0,                0, '0,                1, 0, 0, 0, 16'h0000);

      repeat (2) @(posedge clk);
      #1;
      chkb("rst_valid", o_valid_out, 1'b0);
      chk("rst_data", o_data_out, '0);
      reset = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].v1, tbl[i].d1, tbl[i].v2, tbl[i].d2, tbl[i].ordy);
         #1;
         chkb($sformatf("vec%0d_ready1", i), i_ready1_out, tbl[i].er1);
         chkb($sformatf("vec%0d_ready2", i), i_ready2_out, tbl[i].er2);
         chkb($sformatf("vec%0d_valid", i), o_valid_out, tbl[i].eov);
         if (tbl[i].eov)
            chk($sformatf("vec%0d_tag", i), W'(o_data_out[15:0]), W'(tbl[i].etag));
         step(xk);
      end

      // Source 2 waits while source 1 holds the port, through 5 cycles of backpressure.
      drive(1, mk(1,10,1,0,0,0), 1, mk(2,10,1,0,0,0), 1);
      step(xk);
      drive(1, mk(1,11,0,0,0,0), 1, mk(2,10,1,0,0,0), 1);
      step(xk);
      for (int c = 0; c < 5; c++) begin
         drive(1, mk(1,12,0,0,0,0), 1, mk(2,10,1,0,0,0), 0);
         #1;
         chk("bp_hold_tag", W'(o_data_out[15:0]), W'(16'h100b));
         chkb("bp_ready1", i_ready1_out, 1'b0);
         step(xk);
      end
      drive(1, mk(1,12,0,0,0,0), 1, mk(2,10,1,0,0,0), 1);
      step(xk);
      drive(1, mk(1,13,0,1,2,0), 1, mk(2,10,1,0,0,0), 1);
      #1;
      chkb("lock_ready2", i_ready2_out, 1'b0);
      chk("resume_tag", W'(o_data_out[15:0]), W'(16'h100c));
      step(xk);
      drive(0, '0, 1, mk(2,10,1,0,0,0), 1);
      #1;
      chkb("switch_ready2", i_ready2_out, 1'b1);
      chk("tail_tag", W'(o_data_out[15:0]), W'(16'h100d));
      step(xk);

      // Reset while source 2 is mid-packet: output drops immediately.
      drive(0, '0, 1, mk(2,11,0,0,0,0), 1);
      #1;
      chkb("pre_rst_valid", o_valid_out, 1'b1);
      #1;
      reset = 1'b1;
      #1;
      chkb("midrst_valid", o_valid_out, 1'b0);
      chk("midrst_data", o_data_out, '0);
      #1;
      reset = 1'b0;
      model_reset();
      drive(0, '0, 0, '0, 1);
      step(xk);

      // Randomized packet traffic from both sources.
      for (int k = 1; k <= 2; k++) begin
         slen[k] = $urandom_range(1, 4);
         sidx[k] = 0;
         sseq[k] = 0;
         scur[k] = mk(k, 0, 1, slen[k] == 1, $urandom_range(0, 3), 1);
      end
      for (int c = 0; c < 2000; c++) begin
         for (int k = 1; k <= 2; k++) sval[k] = ($urandom_range(0, 9) < 7);
         drive(sval[1], scur[1], sval[2], scur[2], $urandom_range(0, 3) != 0);
         step(xk);
         if (xk != 0) begin
            sidx[xk]++;
            sseq[xk]++;
            if (sidx[xk] == slen[xk]) begin
               slen[xk] = $urandom_range(1, 4);
               sidx[xk] = 0;
            end
            scur[xk] = mk(xk, sseq[xk], sidx[xk] == 0, sidx[xk] == slen[xk] - 1,
                          $urandom_range(0, 3), 1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arbiter_2to1.md
# arbiter_2to1

Packet-aware 2:1 arbiter that merges two NoC flit streams onto one fabric-interface input port. It sits in front of a NoC router port, between two source blocks (for example a traffic source and a reply path) and the fabric interface. It never interleaves flits of different packets. It alternates between the two sources round-robin at packet boundaries.

## Interface
- NOC_WIDTH, 600: flit word width; a multiple of 4 (four sub-flits of NOC_WIDTH/4 bits).

- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- i_data1_in  in  NOC_WIDTH  source 1 flit word.
- i_valid1_in  in  1  source 1 word valid.
- i_ready1_out  out  1  source 1 word accepted this cycle when high with i_valid1_in.
- i_data2_in  in  NOC_WIDTH  source 2 flit word.
- i_valid2_in  in  1  source 2 word valid.
- i_ready2_out  out  1  source 2 accept.
- o_data_out  out  NOC_WIDTH  merged flit word to fabric.
- o_valid_out  out  1  merged word valid.
- o_ready_in  in  1  fabric can accept o_data_out.

## Operation
- Word fields (W = NOC_WIDTH):
  - Head/SOP = data[W-2].
  - Tail/EOP = data[W-3] | data[3W/4-3] | data[W/2-3] | data[W/4-3]. For W=600 these are bits 597, 447, 297 and 147.
- Transfer on input k: i_validk_in && i_readyk_out.
- State: IDLE, LOCK1, LOCK2; plus last_served flag (1 or 2).
- Grant in IDLE:
  - Only one input valid: that input.
  - Both valid: the input that is not last_served.
  - Neither valid: no grant.
- Grant in LOCKk: input k only; the other input's ready is 0.
- i_readyk_out = grant==k && load_en, where load_en = !o_valid_out || o_ready_in.
- Readys are combinational from valids and o_ready_in; sources must not make valid depend on ready.
- State transitions on a transfer from input k:
  - Head=1, tail=0 in IDLE -> LOCKk.
  - Tail=1 in any state -> IDLE, last_served=k. Covers single-word packets with head+tail.
  - Other words leave state unchanged. A non-head, non-tail word in IDLE is forwarded without locking; this is an upstream protocol error.
- Transferred word is copied unmodified into the output register.
- No ordering is enforced other than packet atomicity. No buffering beyond the one output register.

## Timing
- Reset values: o_valid_out=0, o_data_out=0, state=IDLE, last_served=2, so input 1 wins the first tie.
- Latency: input transfer at edge N appears on o_data_out/o_valid_out after edge N, one cycle.
- Output register rules:
  - Loads when load_en and a transfer occurs.
  - o_valid_out clears when o_ready_in=1 and no new transfer.
  - Holds data and valid while o_ready_in=0.
- Full throughput: one word per cycle while o_ready_in=1 and the granted source is valid.
- Backpressure: o_ready_in=0 with o_valid_out=1 forces both readys to 0 the same cycle.
- Simultaneous tail on granted input and new valid on the other: the switch takes effect the next cycle. A tail transfer and a next-packet head from the other input never occur in the same cycle.
- Reset asserted mid-packet: state returns to IDLE and the output word is dropped (o_valid_out=0) immediately.

## Test plan
- Reset: after reset both readys 0 until a valid arrives. o_valid_out=0 and o_data_out=0 during reset.
- Single source: source 1 sends a 3-word packet (head 598=1; middle; tail 597=1) with o_ready_in=1. Required: o_data_out equals each word one cycle after acceptance, back-to-back, i_ready2_out=0.
- Contention with lock: both sources send 3-word packets starting the same cycle. Required:
  - Source 1 packet wholly, then source 2 packet.
  - No interleave: every SOP at the output is followed by its EOP before the next SOP.
- Round-robin: both sources continuously send single-word packets (head and bit 147 set). Required: output alternates 1,2,1,2.
- Backpressure: o_ready_in=0 for 5 cycles mid-packet. Required:
  - o_data_out and o_valid_out are held.
  - Readys are 0.
  - Transfer resumes with no loss or duplicate after o_ready_in=1.
- Mid-packet other-source valid: source 2 is valid while source 1 is locked after its head. Required: i_ready2_out=0 until source 1's tail word (tail bit 297 set) transfers, then source 2 is granted.
